control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit accumulator CPU.
- Steps a 5-state T-counter (T0..T4) per instruction.
- Decodes the 4-bit opcode nibble from the instruction register, together with the carry and zero flags, into the per-cycle control word. The control word drives PC, MAR, RAM, IR, A, B, ALU, flags and output registers.
- Sits between the instruction register/flags register and every bus-attached datapath register.

Parameters:
- OPCODE_W, 4, width of opcode nibble from IR upper half.
- NUM_STEPS, 5, T-states per instruction; fixed, not shortened per opcode.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  1 = advance one T-state per clock; 0 = pause.
- opcode  input  4  IR upper nibble; valid from T2 onward.
- carry_flag  input  1  registered carry from flags register.
- zero_flag  input  1  registered zero from flags register.
- pc_out, pc_inc, pc_load  output  1 each  program counter controls.
- mar_load  output  1  memory address register load.
- ram_out, ram_load  output  1 each  RAM bus drive / write.
- ir_load, ir_out  output  1 each  IR load / drive IR low nibble onto bus.
- a_load, a_out  output  1 each  accumulator controls.
- b_load  output  1  B register load.
- alu_out, alu_sub  output  1 each  ALU drive / subtract select.
- flags_load  output  1  flags register capture.
- out_load  output  1  output display register load.
- tstate  output  5  one-hot current T-state (bit n = Tn), for display.
- halted  output  1  HLT executed.

Behaviour:
- State:
  - 5-state T-counter plus a sticky halt bit.
  - Async reset (rst_n=0) forces T0, halted=0, tstate=5'b00001.
  - While rst_n=0, all control outputs are 0.
- Advance rule:
  - At a posedge with run=1 and halted=0: T0→T1→T2→T3→T4→T0 (wrap).
  - With run=0: T-state holds, and all control outputs are forced 0 so no register double-loads.
  - On run returning to 1: resume in the held T-state, with its controls asserted that cycle.
- Control outputs:
  - Combinational decode of (T-state, opcode, flags), gated by run & ~halted & rst_n.
  - Any signal not listed for a step is 0.
- Fetch (every opcode):
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- Execute, T2/T3/T4:
  - NOP 0000: none.
  - LDA 0001: T2 ir_out, mar_load; T3 ram_out, a_load.
  - ADD 0010: T2 ir_out, mar_load; T3 ram_out, b_load; T4 alu_out, a_load, flags_load.
  - SUB 0011: as ADD, plus alu_sub during T4 only.
  - STA 0100: T2 ir_out, mar_load; T3 a_out, ram_load.
  - LDI 0101: T2 ir_out, a_load.
  - JMP 0110: T2 ir_out, pc_load.
  - JC 0111: T2 ir_out, pc_load only if carry_flag=1, else none.
  - JZ 1000: T2 ir_out, pc_load only if zero_flag=1, else none.
  - OUT 1110: T2 a_out, out_load.
  - HLT 1111: T2 no controls; halted set at the T2 posedge (run=1). Thereafter the T-state freezes, all controls are 0 and halted=1 until rst_n.
  - Undefined opcodes (1001–1101): treated as NOP, full 5 steps.
- Flags are sampled combinationally during T2 only; flag changes in T3/T4 have no effect.
- Latency: every non-HLT instruction occupies exactly 5 enabled cycles.
- Bus safety: at most one of pc_out, ram_out, ir_out, a_out, alu_out is high in any cycle. This is an assertion for verification.
- Reset mid-instruction: immediate return to T0; the partially executed instruction is abandoned.

Decomposition:
- Shared package cpu_pkg:
  - Opcode localparams: OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT.
  - T-state one-hot constants T0..T4.
- One sub-module, step_counter: 5-state ring with enable, async active-low reset and freeze input.
- Decode stays in control_sequencer.

Test Plan:
1. Reset then run=1, opcode=0000 for 10 clocks → tstate cycles 00001→00010→00100→01000→10000→00001. pc_out&mar_load in T0; ram_out&ir_load&pc_inc in T1; no controls in T2–T4.
2. opcode=0010 (ADD) → T2 {ir_out,mar_load}, T3 {ram_out,b_load}, T4 {alu_out,a_load,flags_load}, alu_sub=0. Repeat with 0011 → alu_sub=1 in T4 only.
3. opcode=0111, carry_flag=0 → T2 no pc_load. carry_flag=1 → T2 {ir_out,pc_load}. Same pair for JZ with zero_flag.
4. opcode=1111 → halted=1 after the T2 edge. tstate stays 00100 and all controls stay 0 for 20 clocks. rst_n pulse → halted=0, tstate=00001.
5. In T3 of LDA, drop run for 3 clocks → tstate held at 01000 with all controls 0. Raise run → ram_out&a_load asserted for exactly one cycle, then T4.
6. Assert rst_n=0 asynchronously mid-T3 of STA → ram_load drops without waiting for a clock edge, tstate=00001. The one-hot and bus-exclusivity assertions hold throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU.
// Opcodes, T-state encodings and the control word bundle.
package cpu_pkg;

  localparam int OPCODE_W  = 4;
  localparam int NUM_STEPS = 5;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  localparam logic [NUM_STEPS-1:0] T0 = 5'b00001;
  localparam logic [NUM_STEPS-1:0] T1 = 5'b00010;
  localparam logic [NUM_STEPS-1:0] T2 = 5'b00100;
  localparam logic [NUM_STEPS-1:0] T3 = 5'b01000;
  localparam logic [NUM_STEPS-1:0] T4 = 5'b10000;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_load;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_step_counter.sv
// One-hot T-state ring for the sequencer.
// Advances on en unless freeze holds it in place.
module step_counter
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 freeze,
  output logic [NUM_STEPS-1:0] tstate
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstate <= T0;
    end else if (en && !freeze) begin
      tstate <= {tstate[NUM_STEPS-2:0], tstate[NUM_STEPS-1]};
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-state ring plus opcode/flag decode
// into the per-cycle control word.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 carry_flag,
  input  logic                 zero_flag,
  output logic                 pc_out,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 mar_load,
  output logic                 ram_out,
  output logic                 ram_load,
  output logic                 ir_load,
  output logic                 ir_out,
  output logic                 a_load,
  output logic                 a_out,
  output logic                 b_load,
  output logic                 alu_out,
  output logic                 alu_sub,
  output logic                 flags_load,
  output logic                 out_load,
  output logic [NUM_STEPS-1:0] tstate,
  output logic                 halted
);

  logic  halted_q;
  logic  hlt_now;
  logic  active;
  ctrl_t ctrl;

  assign hlt_now = tstate[2] & (opcode == OP_HLT);
  assign active  = run & ~halted_q & rst_n;

  // HLT freezes the ring at T2 on the same edge that sets halt
  step_counter u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (run & ~halted_q),
    .freeze (hlt_now),
    .tstate (tstate)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if (run && hlt_now) begin
      halted_q <= 1'b1;
    end
  end

  always_comb begin
    ctrl = '0;
    if (active) begin
      unique case (1'b1)
        tstate[0]: begin
          ctrl.pc_out   = 1'b1;
          ctrl.mar_load = 1'b1;
        end
        tstate[1]: begin
          ctrl.ram_out = 1'b1;
          ctrl.ir_load = 1'b1;
          ctrl.pc_inc  = 1'b1;
        end
        tstate[2]: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.ir_out   = 1'b1;
              ctrl.mar_load = 1'b1;
            end
            OP_LDI: begin
              ctrl.ir_out = 1'b1;
              ctrl.a_load = 1'b1;
            end
            OP_JMP: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_load = 1'b1;
            end
            OP_JC: begin
              ctrl.ir_out  = carry_flag;
              ctrl.pc_load = carry_flag;
            end
            OP_JZ: begin
              ctrl.ir_out  = zero_flag;
              ctrl.pc_load = zero_flag;
            end
            OP_OUT: begin
              ctrl.a_out    = 1'b1;
              ctrl.out_load = 1'b1;
            end
            default: ;
          endcase
        end
        tstate[3]: begin
          case (opcode)
            OP_LDA: begin
              ctrl.ram_out = 1'b1;
              ctrl.a_load  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ram_out = 1'b1;
              ctrl.b_load  = 1'b1;
            end
            OP_STA: begin
              ctrl.a_out    = 1'b1;
              ctrl.ram_load = 1'b1;
            end
            default: ;
          endcase
        end
        tstate[4]: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.alu_out    = 1'b1;
            ctrl.a_load     = 1'b1;
            ctrl.flags_load = 1'b1;
            ctrl.alu_sub    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_out     = ctrl.pc_out;
  assign pc_inc     = ctrl.pc_inc;
  assign pc_load    = ctrl.pc_load;
  assign mar_load   = ctrl.mar_load;
  assign ram_out    = ctrl.ram_out;
  assign ram_load   = ctrl.ram_load;
  assign ir_load    = ctrl.ir_load;
  assign ir_out     = ctrl.ir_out;
  assign a_load     = ctrl.a_load;
  assign a_out      = ctrl.a_out;
  assign b_load     = ctrl.b_load;
  assign alu_out    = ctrl.alu_out;
  assign alu_sub    = ctrl.alu_sub;
  assign flags_load = ctrl.flags_load;
  assign out_load   = ctrl.out_load;
  assign halted     = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: step/halt model plus a
// table of control sets per (step, opcode, flags).
module tb_control_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load;
  logic ir_load, ir_out, a_load, a_out, b_load, alu_out;
  logic alu_sub, flags_load, out_load, halted;
  logic [4:0] tstate;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load),
    .mar_load(mar_load), .ram_out(ram_out), .ram_load(ram_load),
    .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
    .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
    .alu_sub(alu_sub), .flags_load(flags_load),
    .out_load(out_load), .tstate(tstate), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [14:0] PCO  = 15'd1 << 14;
  localparam logic [14:0] PCI  = 15'd1 << 13;
  localparam logic [14:0] PCL  = 15'd1 << 12;
  localparam logic [14:0] MARL = 15'd1 << 11;
  localparam logic [14:0] RAMO = 15'd1 << 10;
  localparam logic [14:0] RAML = 15'd1 << 9;
  localparam logic [14:0] IRL  = 15'd1 << 8;
  localparam logic [14:0] IRO  = 15'd1 << 7;
  localparam logic [14:0] AL   = 15'd1 << 6;
  localparam logic [14:0] AO   = 15'd1 << 5;
  localparam logic [14:0] BL   = 15'd1 << 4;
  localparam logic [14:0] ALUO = 15'd1 << 3;
  localparam logic [14:0] SUBS = 15'd1 << 2;
  localparam logic [14:0] FL   = 15'd1 << 1;
  localparam logic [14:0] OUTL = 15'd1;

  logic [14:0] act;
  assign act = {pc_out, pc_inc, pc_load, mar_load, ram_out,
                ram_load, ir_load, ir_out, a_load, a_out,
                b_load, alu_out, alu_sub, flags_load, out_load};

  int total = 0;
  int bad   = 0;
  int m_step;
  bit m_halt;

  function automatic logic [14:0] spec_ctrl(
    input int step, input logic [3:0] op,
    input logic c, input logic z);
    logic [14:0] w;
    w = '0;
    if (step == 0) return PCO | MARL;
    if (step == 1) return RAMO | IRL | PCI;
    case (op)
      4'h1: if (step == 2) w = IRO | MARL;
            else if (step == 3) w = RAMO | AL;
      4'h2, 4'h3: begin
        if (step == 2) w = IRO | MARL;
        else if (step == 3) w = RAMO | BL;
        else w = ALUO | AL | FL | ((op == 4'h3) ? SUBS : 15'd0);
      end
      4'h4: if (step == 2) w = IRO | MARL;
            else if (step == 3) w = AO | RAML;
      4'h5: if (step == 2) w = IRO | AL;
      4'h6: if (step == 2) w = IRO | PCL;
      4'h7: if (step == 2 && c) w = IRO | PCL;
      4'h8: if (step == 2 && z) w = IRO | PCL;
      4'hE: if (step == 2) w = AO | OUTL;
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, a, e, $time);
    end
  endtask

  task automatic check_cycle();
    logic [14:0] exp;
    logic [4:0]  bus;
    exp = (rst_n && run && !m_halt) ?
          spec_ctrl(m_step, opcode, carry_flag, zero_flag) : 15'd0;
    bus = {pc_out, ram_out, ir_out, a_out, alu_out};
    chk("ctrl", {17'd0, act}, {17'd0, exp});
    chk("tstate", {27'd0, tstate}, 32'd1 << m_step);
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("onehot", {31'd0, $onehot(tstate)}, 32'd1);
    chk("bus_excl", {31'd0, ($countones(bus) <= 1)}, 32'd1);
  endtask

  task automatic model_edge();
    if (rst_n && run && !m_halt) begin
      if (m_step == 2 && opcode == 4'hF) m_halt = 1'b1;
      else m_step = (m_step + 1) % 5;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic align();
    for (int i = 0; i < 6 && m_step != 0; i++) cyc();
    chk("align", m_step, 0);
  endtask

  task automatic model_reset();
    m_step = 0;
    m_halt = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; opcode = 4'h0;
    carry_flag = 1'b0; zero_flag = 1'b0;
    model_reset();
    #12;
    chk("rst_tstate", {27'd0, tstate}, 32'h1);
    chk("rst_ctrl", {17'd0, act}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("t0_fetch", {29'd0, pc_out, mar_load, ram_out}, 32'b110);
    check_cycle();

    // NOP sweep
    repeat (10) cyc();

    // ADD then SUB
    opcode = 4'h2;
    repeat (4) cyc();
    chk("add_t4", {28'd0, alu_out, a_load, flags_load, alu_sub},
        32'b1110);
    cyc();
    opcode = 4'h3;
    repeat (3) cyc();
    chk("sub_t3_nosub", {31'd0, alu_sub}, 32'd0);
    cyc();
    chk("sub_t4", {31'd0, alu_sub}, 32'd1);
    cyc();

    // conditional jumps
    opcode = 4'h7; carry_flag = 1'b0;
    repeat (2) cyc();
    chk("jc_c0", {30'd0, ir_out, pc_load}, 32'b00);
    repeat (3) cyc();
    carry_flag = 1'b1;
    repeat (2) cyc();
    chk("jc_c1", {30'd0, ir_out, pc_load}, 32'b11);
    carry_flag = 1'b0;
    repeat (3) cyc();
    opcode = 4'h8; zero_flag = 1'b0;
    repeat (2) cyc();
    chk("jz_z0", {31'd0, pc_load}, 32'd0);
    repeat (3) cyc();
    zero_flag = 1'b1;
    repeat (2) cyc();
    chk("jz_z1", {31'd0, pc_load}, 32'd1);
    zero_flag = 1'b0;
    repeat (3) cyc();

    // HLT
    align();
    opcode = 4'hF;
    repeat (3) cyc();
    chk("hlt_set", {26'd0, halted, tstate}, {26'd0, 1'b1, 5'b00100});
    repeat (20) cyc();
    chk("hlt_hold", {17'd0, act}, 32'd0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("hlt_clear", {26'd0, halted, tstate}, 32'b000001);
    rst_n = 1'b1;
    opcode = 4'h0;

    // LDA pause in T3
    align();
    opcode = 4'h1;
    repeat (3) cyc();
    run = 1'b0;
    #1 chk("pause_gate", {17'd0, act}, 32'd0);
    repeat (3) cyc();
    chk("pause_hold", {27'd0, tstate}, 32'b01000);
    run = 1'b1;
    #1 chk("resume_t3", {30'd0, ram_out, a_load}, 32'b11);
    cyc();
    chk("resume_t4", {26'd0, a_load, tstate}, {26'd0, 1'b0, 5'b10000});
    cyc();

    // async reset mid-T3 of STA
    align();
    opcode = 4'h4;
    repeat (3) cyc();
    chk("sta_t3", {31'd0, ram_load}, 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("sta_abort", {26'd0, ram_load, tstate}, 32'b000001);
    rst_n = 1'b1;
    #1 check_cycle();

    // randomized traffic, HLT excluded
    for (int n = 0; n < 400; n++) begin
      if (m_step == 0) opcode = 4'($urandom_range(0, 14));
      run        = ($urandom_range(0, 7) != 0);
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag  = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
